// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: per-pipe result handshake in, per-port PRF write,
// wakeup broadcast and ROB completion out.
interface writeback_arbiter_if #(
    parameter int NUM_PIPES = 4,
    parameter int WB_PORTS  = 2,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5
);
    logic [NUM_PIPES-1:0]                in_valid;
    logic [NUM_PIPES-1:0]                in_ready;
    logic [NUM_PIPES-1:0]                in_rd_en;
    logic [NUM_PIPES-1:0][PRF_IDX_W-1:0] in_rd_idx;
    logic [NUM_PIPES-1:0][31:0]          in_rd_data;
    logic [NUM_PIPES-1:0][ROB_IDX_W-1:0] in_rob_idx;

    logic [WB_PORTS-1:0]                 wb_en;
    logic [WB_PORTS-1:0][PRF_IDX_W-1:0]  wb_idx;
    logic [WB_PORTS-1:0][31:0]           wb_data;
    logic [WB_PORTS-1:0]                 ctb_valid;
    logic [WB_PORTS-1:0][PRF_IDX_W-1:0]  ctb_idx;
    logic [WB_PORTS-1:0]                 cm_valid;
    logic [WB_PORTS-1:0][ROB_IDX_W-1:0]  cm_rob_idx;

    // Execution pipes / bench side.
    modport master (
        output in_valid, in_rd_en, in_rd_idx, in_rd_data, in_rob_idx,
        input  in_ready,
        input  wb_en, wb_idx, wb_data, ctb_valid, ctb_idx, cm_valid, cm_rob_idx
    );

    // Arbiter side.
    modport slave (
        input  in_valid, in_rd_en, in_rd_idx, in_rd_data, in_rob_idx,
        output in_ready,
        output wb_en, wb_idx, wb_data, ctb_valid, ctb_idx, cm_valid, cm_rob_idx
    );
endinterface

// File: rtl/writeback_arbiter.sv
// EX->WB arbiter: per-pipe result FIFOs with empty-queue bypass, round-robin grant
// of up to WB_PORTS results per cycle onto registered PRF/wakeup/completion ports.
module writeback_arbiter #(
    parameter int NUM_PIPES = 4,
    parameter int WB_PORTS  = 2,
    parameter int QDEPTH    = 2,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               recover,
    writeback_arbiter_if.slave bus
);
    localparam int PIPE_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam int QPTR_W = $clog2(QDEPTH);
    localparam logic [QPTR_W:0] FULL = (QPTR_W+1)'(QDEPTH);

    typedef struct packed {
        logic                 rd_en;
        logic [PRF_IDX_W-1:0] rd_idx;
        logic [31:0]          data;
        logic [ROB_IDX_W-1:0] rob;
    } result_t;

    result_t           mem   [NUM_PIPES][QDEPTH];
    logic [QPTR_W-1:0] head  [NUM_PIPES];
    logic [QPTR_W-1:0] tail  [NUM_PIPES];
    logic [QPTR_W:0]   count [NUM_PIPES];
    logic [PIPE_W-1:0] rr_ptr;

    result_t              incoming [NUM_PIPES];
    result_t              cand     [NUM_PIPES];
    logic [NUM_PIPES-1:0] ready, accept, cand_valid, granted, deq, enq;
    logic [WB_PORTS-1:0]  port_vld;
    logic [PIPE_W-1:0]    port_pipe [WB_PORTS];
    logic [PIPE_W-1:0]    last_pipe;

    logic [WB_PORTS-1:0]                wb_en_q, cm_valid_q;
    logic [WB_PORTS-1:0][PRF_IDX_W-1:0] wb_idx_q;
    logic [WB_PORTS-1:0][31:0]          wb_data_q;
    logic [WB_PORTS-1:0][ROB_IDX_W-1:0] cm_rob_q;

    function automatic logic [PIPE_W-1:0] pipe_at(input logic [PIPE_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_PIPES) s = s - NUM_PIPES;
        return PIPE_W'(s);
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PIPES; p++) begin
            // ready depends only on registered count, never on in_valid
            ready[p]      = (count[p] != FULL);
            incoming[p]   = '{rd_en: bus.in_rd_en[p], rd_idx: bus.in_rd_idx[p],
                              data: bus.in_rd_data[p], rob: bus.in_rob_idx[p]};
            accept[p]     = bus.in_valid[p] & ready[p];
            cand_valid[p] = (count[p] != '0) | accept[p];
            cand[p]       = (count[p] != '0) ? mem[p][head[p]] : incoming[p];
        end
    end

    // Port k takes the first not-yet-granted candidate in round-robin order from rr_ptr.
    always_comb begin
        logic              found;
        logic [PIPE_W-1:0] p;
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        found     = 1'b0;
        p         = '0;
        granted   = '0;
        port_vld  = '0;
        last_pipe = rr_ptr;
        for (int k = 0; k < WB_PORTS; k++) begin
            port_pipe[k] = '0;
            found        = 1'b0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                p = pipe_at(rr_ptr, i);
                if (!found && cand_valid[p] && !granted[p]) begin
                    found        = 1'b1;
                    granted[p]   = 1'b1;
                    port_vld[k]  = 1'b1;
                    port_pipe[k] = p;
                    last_pipe    = p;
                end
            end
        end
        for (int q = 0; q < NUM_PIPES; q++) begin
            deq[q] = granted[q] & (count[q] != '0);
            enq[q] = accept[q] & ~(granted[q] & (count[q] == '0));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                head[p]  <= '0;
                tail[p]  <= '0;
                count[p] <= '0;
            end
            rr_ptr     <= '0;
            wb_en_q    <= '0;
            cm_valid_q <= '0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
            cm_rob_q   <= '0;
        end else if (recover) begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                head[p]  <= '0;
                tail[p]  <= '0;
                count[p] <= '0;
            end
            rr_ptr     <= '0;
            wb_en_q    <= '0;
            cm_valid_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                if (deq[p]) head[p] <= head[p] + 1'b1;
                if (enq[p]) tail[p] <= tail[p] + 1'b1;
                if (enq[p] && !deq[p])      count[p] <= count[p] + 1'b1;
                else if (deq[p] && !enq[p]) count[p] <= count[p] - 1'b1;
            end
            if (|port_vld) rr_ptr <= pipe_at(last_pipe, 1);
            for (int k = 0; k < WB_PORTS; k++) begin
                cm_valid_q[k] <= port_vld[k];
                wb_en_q[k]    <= port_vld[k] & cand[port_pipe[k]].rd_en
                                 & (cand[port_pipe[k]].rd_idx != '0);
                wb_idx_q[k]   <= cand[port_pipe[k]].rd_idx;
                wb_data_q[k]  <= cand[port_pipe[k]].data;
                cm_rob_q[k]   <= cand[port_pipe[k]].rob;
            end
        end
    end

    // NOTE: queue storage is not reset; head/tail/count define which entries are live.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_PIPES; p++) begin
            if (enq[p] && !recover) mem[p][tail[p]] <= incoming[p];
        end
    end

    assign bus.in_ready   = ready;
    assign bus.wb_en      = wb_en_q;
    assign bus.wb_idx     = wb_idx_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.ctb_valid  = wb_en_q;
    assign bus.ctb_idx    = wb_idx_q;
    assign bus.cm_valid   = cm_valid_q;
    assign bus.cm_rob_idx = cm_rob_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the per-pipe buffering and round-robin grant.
module tb_writeback_arbiter;
    localparam int NP = 4;
    localparam int WB = 2;
    localparam int QD = 2;
    localparam int PW = 6;
    localparam int RW = 5;

    typedef struct packed {
        logic          rd_en;
        logic [PW-1:0] idx;
        logic [31:0]   data;
        logic [RW-1:0] rob;
    } res_t;

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic recover = 1'b0;

    writeback_arbiter_if #(.NUM_PIPES(NP), .WB_PORTS(WB), .PRF_IDX_W(PW), .ROB_IDX_W(RW)) bus ();

    writeback_arbiter #(.NUM_PIPES(NP), .WB_PORTS(WB), .QDEPTH(QD), .PRF_IDX_W(PW), .ROB_IDX_W(RW)) dut (
        .clock   (clock),
        .reset   (reset),
        .recover (recover),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    res_t          mq [NP][$];
    int            m_rr;
    logic [WB-1:0] exp_cm, exp_wb;
    res_t          exp_res [WB];
    logic [NP-1:0] exp_ready;

    task automatic set_in(input int p, input logic v, input logic en, input int idx,
                          input logic [31:0] data, input int rob);
        bus.in_valid[p]   = v;
        bus.in_rd_en[p]   = en;
        bus.in_rd_idx[p]  = PW'(idx);
        bus.in_rd_data[p] = data;
        bus.in_rob_idx[p] = RW'(rob);
    endtask

    task automatic idle();
        bus.in_valid = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) mq[i].delete();
        m_rr      = 0;
        exp_cm    = '0;
        exp_wb    = '0;
        exp_ready = '1;
    endtask

    // Expected result of the coming clock edge given current inputs and model state.
    task automatic model_step();
        res_t inc [NP];
        res_t cand [NP];
        bit   cv [NP];
        bit   acc [NP];
        bit   took [NP];
        int   ng, last, p;
        exp_cm = '0;
        exp_wb = '0;
        for (int k = 0; k < WB; k++) exp_res[k] = '0;
        if (recover === 1'b1) begin
            for (int i = 0; i < NP; i++) mq[i].delete();
            m_rr = 0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                inc[i]  = '{rd_en: bus.in_rd_en[i], idx: bus.in_rd_idx[i],
                            data: bus.in_rd_data[i], rob: bus.in_rob_idx[i]};
                acc[i]  = (bus.in_valid[i] === 1'b1) && (mq[i].size() < QD);
                took[i] = 1'b0;
                if (mq[i].size() > 0) begin
                    cv[i]   = 1'b1;
                    cand[i] = mq[i][0];
                end else begin
                    cv[i]   = acc[i];
                    cand[i] = inc[i];
                end
            end
            ng   = 0;
            last = 0;
            for (int i = 0; i < NP; i++) begin
                p = (m_rr + i) % NP;
                if (cv[p] && ng < WB) begin
                    exp_cm[ng]  = 1'b1;
                    exp_wb[ng]  = cand[p].rd_en && (cand[p].idx != 0);
                    exp_res[ng] = cand[p];
                    took[p]     = 1'b1;
                    last        = p;
                    ng++;
                end
            end
            if (ng > 0) m_rr = (last + 1) % NP;
            for (int i = 0; i < NP; i++) begin
                if (mq[i].size() > 0) begin
                    if (took[i]) void'(mq[i].pop_front());
                    if (acc[i]) mq[i].push_back(inc[i]);
                end else if (acc[i] && !took[i]) begin
                    mq[i].push_back(inc[i]);
                end
            end
        end
        for (int i = 0; i < NP; i++) exp_ready[i] = (mq[i].size() < QD);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_all(input int base);
        for (int p = 0; p < NP; p++)
            set_in(p, 1'b1, 1'b1, 1 + (base * 4 + p) % 63, 32'hA000_0000 + 32'(base * 16 + p), (base * 4 + p) % 32);
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({bus.cm_valid, bus.wb_en, bus.ctb_valid, bus.wb_idx, bus.wb_data, bus.cm_rob_idx, bus.ctb_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: cm=%b wb=%b ctb=%b idx=%h, required all zero",
                     bus.cm_valid, bus.wb_en, bus.ctb_valid, bus.wb_idx);
        end
        n_checks++;
        if (bus.in_ready !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1111", bus.in_ready);
        end
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        set_in(1, 1'b1, 1'b1, 5, 32'hDEAD_BEEF, 3);
        tick();
        idle();
        n_checks++;
        if (bus.cm_valid !== 2'b01 || bus.wb_en !== 2'b01 || bus.ctb_valid !== 2'b01) begin
            n_fail++;
            $display("FAIL single_valids: cm=%b wb=%b ctb=%b, required 01 01 01", bus.cm_valid, bus.wb_en, bus.ctb_valid);
        end
        n_checks++;
        if (bus.wb_idx[0] !== 6'd5 || bus.ctb_idx[0] !== 6'd5 || bus.wb_data[0] !== 32'hDEAD_BEEF || bus.cm_rob_idx[0] !== 5'd3) begin
            n_fail++;
            $display("FAIL single_fields: idx=%0d ctb=%0d data=%h rob=%0d, required 5 5 deadbeef 3",
                     bus.wb_idx[0], bus.ctb_idx[0], bus.wb_data[0], bus.cm_rob_idx[0]);
        end
        tick();
        n_checks++;
        if (bus.cm_valid !== 2'b00 || bus.wb_en !== 2'b00) begin
            n_fail++;
            $display("FAIL single_after: cm=%b wb=%b, required 00 00", bus.cm_valid, bus.wb_en);
        end
    endtask

    task automatic test_all_four();
        recover = 1'b1;
        tick();
        recover = 1'b0;
        for (int p = 0; p < NP; p++) set_in(p, 1'b1, 1'b1, 10 + p, 32'h1000 + 32'(p), p);
        tick();
        idle();
        n_checks++;
        if (bus.cm_valid !== 2'b11 || bus.cm_rob_idx[0] !== 5'd0 || bus.cm_rob_idx[1] !== 5'd1 ||
            bus.wb_idx[0] !== 6'd10 || bus.wb_idx[1] !== 6'd11 || bus.in_ready !== 4'hF) begin
            n_fail++;
            $display("FAIL all4_first: cm=%b rob=%0d,%0d idx=%0d,%0d rdy=%b, required 11 0,1 10,11 1111",
                     bus.cm_valid, bus.cm_rob_idx[0], bus.cm_rob_idx[1], bus.wb_idx[0], bus.wb_idx[1], bus.in_ready);
        end
        tick();
        n_checks++;
        if (bus.cm_valid !== 2'b11 || bus.cm_rob_idx[0] !== 5'd2 || bus.cm_rob_idx[1] !== 5'd3 ||
            bus.wb_data[0] !== 32'h1002 || bus.wb_data[1] !== 32'h1003) begin
            n_fail++;
            $display("FAIL all4_second: cm=%b rob=%0d,%0d data=%h,%h, required 11 2,3 1002,1003",
                     bus.cm_valid, bus.cm_rob_idx[0], bus.cm_rob_idx[1], bus.wb_data[0], bus.wb_data[1]);
        end
        // rr_ptr is back at 0: pipe0 must win port0 over pipe3
        set_in(3, 1'b1, 1'b1, 20, 32'h33, 9);
        set_in(0, 1'b1, 1'b1, 21, 32'h00, 8);
        tick();
        idle();
        n_checks++;
        if (bus.cm_valid !== 2'b11 || bus.cm_rob_idx[0] !== 5'd8 || bus.cm_rob_idx[1] !== 5'd9) begin
            n_fail++;
            $display("FAIL all4_rr_wrap: cm=%b rob=%0d,%0d, required 11 8,9",
                     bus.cm_valid, bus.cm_rob_idx[0], bus.cm_rob_idx[1]);
        end
        tick();
    endtask

    task automatic test_store_x0();
        set_in(3, 1'b1, 1'b0, 9, 32'h5555, 7);
        tick();
        idle();
        n_checks++;
        if (bus.cm_valid !== 2'b01 || bus.cm_rob_idx[0] !== 5'd7 || bus.wb_en !== 2'b00 || bus.ctb_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL store: cm=%b rob=%0d wb=%b ctb=%b, required 01 7 00 00",
                     bus.cm_valid, bus.cm_rob_idx[0], bus.wb_en, bus.ctb_valid);
        end
        set_in(0, 1'b1, 1'b1, 0, 32'h7777, 4);
        tick();
        idle();
        n_checks++;
        if (bus.cm_valid !== 2'b01 || bus.cm_rob_idx[0] !== 5'd4 || bus.wb_en !== 2'b00 || bus.ctb_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL x0_write: cm=%b rob=%0d wb=%b ctb=%b, required 01 4 00 00",
                     bus.cm_valid, bus.cm_rob_idx[0], bus.wb_en, bus.ctb_valid);
        end
        tick();
    endtask

    task automatic test_saturate();
        logic saw_full;
        saw_full = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c < 6) drive_all(c + 1); else idle();
            tick();
            if (bus.in_ready !== 4'hF) saw_full = 1'b1;
            n_checks++;
            if (bus.cm_valid !== exp_cm || bus.wb_en !== exp_wb || bus.ctb_valid !== exp_wb || bus.in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL sat_valids c%0d: cm=%b wb=%b ctb=%b rdy=%b, required cm=%b wb=%b rdy=%b",
                         c, bus.cm_valid, bus.wb_en, bus.ctb_valid, bus.in_ready, exp_cm, exp_wb, exp_ready);
            end
            for (int k = 0; k < WB; k++) if (exp_cm[k]) begin
                n_checks++;
                if (bus.cm_rob_idx[k] !== exp_res[k].rob || bus.wb_data[k] !== exp_res[k].data) begin
                    n_fail++;
                    $display("FAIL sat_port%0d c%0d: rob=%0d data=%h, required rob=%0d data=%h",
                             k, c, bus.cm_rob_idx[k], bus.wb_data[k], exp_res[k].rob, exp_res[k].data);
                end
            end
        end
        n_checks++;
        if (saw_full !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_backpressure: in_ready never dropped, required a 0 while saturated");
        end
    endtask

    task automatic test_recover();
        for (int c = 0; c < 3; c++) begin
            drive_all(c + 10);
            tick();
        end
        idle();
        set_in(0, 1'b1, 1'b1, 44, 32'hBAD0_0000, 30);
        recover = 1'b1;
        tick();
        recover = 1'b0;
        idle();
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (bus.cm_valid !== 2'b00 || bus.wb_en !== 2'b00 || bus.ctb_valid !== 2'b00 || bus.in_ready !== 4'hF) begin
                n_fail++;
                $display("FAIL recover_flush c%0d: cm=%b wb=%b ctb=%b rdy=%b, required 00 00 00 1111",
                         c, bus.cm_valid, bus.wb_en, bus.ctb_valid, bus.in_ready);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++)
                set_in(p, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) != 0),
                       $urandom_range(0, 63), $urandom, $urandom_range(0, 31));
            recover = ($urandom_range(0, 39) == 0);
            tick();
            n_checks++;
            if (bus.cm_valid !== exp_cm || bus.wb_en !== exp_wb || bus.ctb_valid !== exp_wb || bus.in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rnd_valids c%0d: cm=%b wb=%b ctb=%b rdy=%b, required cm=%b wb=%b rdy=%b",
                         c, bus.cm_valid, bus.wb_en, bus.ctb_valid, bus.in_ready, exp_cm, exp_wb, exp_ready);
            end
            for (int k = 0; k < WB; k++) if (exp_cm[k]) begin
                n_checks++;
                if (bus.cm_rob_idx[k] !== exp_res[k].rob ||
                    (exp_wb[k] && (bus.wb_idx[k] !== exp_res[k].idx || bus.ctb_idx[k] !== exp_res[k].idx ||
                                   bus.wb_data[k] !== exp_res[k].data))) begin
                    n_fail++;
                    $display("FAIL rnd_port%0d c%0d: rob=%0d idx=%0d data=%h, required rob=%0d idx=%0d data=%h",
                             k, c, bus.cm_rob_idx[k], bus.wb_idx[k], bus.wb_data[k],
                             exp_res[k].rob, exp_res[k].idx, exp_res[k].data);
                end
            end
        end
        recover = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        drive_all(20);
        tick();
        drive_all(21);
        tick();
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.cm_valid, bus.wb_en, bus.ctb_valid, bus.wb_idx, bus.wb_data, bus.cm_rob_idx} !== '0 || bus.in_ready !== 4'hF) begin
            n_fail++;
            $display("FAIL async_reset: cm=%b wb=%b ctb=%b rdy=%b, required zeros and rdy 1111",
                     bus.cm_valid, bus.wb_en, bus.ctb_valid, bus.in_ready);
        end
        idle();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        set_in(3, 1'b1, 1'b1, 40, 32'hCAFE_0003, 22);
        set_in(0, 1'b1, 1'b1, 41, 32'hCAFE_0000, 21);
        tick();
        idle();
        n_checks++;
        if (bus.cm_valid !== 2'b11 || bus.cm_rob_idx[0] !== 5'd21 || bus.cm_rob_idx[1] !== 5'd22 ||
            bus.wb_data[0] !== 32'hCAFE_0000) begin
            n_fail++;
            $display("FAIL post_reset: cm=%b rob=%0d,%0d data0=%h, required 11 21,22 cafe0000",
                     bus.cm_valid, bus.cm_rob_idx[0], bus.cm_rob_idx[1], bus.wb_data[0]);
        end
        tick();
        n_checks++;
        if (bus.cm_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_stale: cm=%b, required 00", bus.cm_valid);
        end
    endtask

    initial begin
        bus.in_valid   = '0;
        bus.in_rd_en   = '0;
        bus.in_rd_idx  = '0;
        bus.in_rd_data = '0;
        bus.in_rob_idx = '0;
        #1;
        reset = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_store_x0();
        test_saturate();
        test_recover();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
